// File: rtl/pong_raster_renderer.sv
// VGA-style raster scanner that draws the pong ball and paddles from frame-start snapshots.
// Optional centre net is enabled by defining PONG_RENDER_NET_EN.
module pong_raster_renderer #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int SCALE_SHIFT   = 3,
  parameter int PADDLE_EXTENT = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pix_ce,
  input  logic [7:0] i_ball_x,
  input  logic [7:0] i_ball_y,
  input  logic [7:0] i_left_paddle_y,
  input  logic [7:0] i_right_paddle_y,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_pixel,
  output logic       o_active,
  output logic       o_frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int GW      = H_ACTIVE >> SCALE_SHIFT;

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS_END    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]    GX_LEFT      = 8'd0;
  localparam logic [7:0]    GX_RIGHT     = 8'(GW - 1);
  localparam logic [8:0]    PAD_EXT      = 9'(PADDLE_EXTENT);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [7:0]    r_snap_ball_x;
  logic [7:0]    r_snap_ball_y;
  logic [7:0]    r_snap_left;
  logic [7:0]    r_snap_right;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_pixel;
  logic          r_active;
  logic          r_frame_tick;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_vis;
  logic          w_hsync_n;
  logic          w_vsync_n;
  logic [7:0]    w_gx;
  logic [7:0]    w_gy;
  logic          w_ball;
  logic          w_lpad;
  logic          w_rpad;
  logic          w_draw;
  logic          w_tick;

  // Paddle distance uses a 9-bit signed difference so rows never alias across the 8-bit wrap.
  function automatic logic [8:0] absDiff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) absDiff = 9'(-d);
    else       absDiff = 9'(d);
  endfunction

  assign w_h_last  = (r_h_cnt == H_LAST);
  assign w_v_last  = (r_v_cnt == V_LAST);
  assign w_vis     = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);
  assign w_hsync_n = (r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END);
  assign w_vsync_n = (r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END);
  assign w_gx      = 8'(r_h_cnt >> SCALE_SHIFT);
  assign w_gy      = 8'(r_v_cnt >> SCALE_SHIFT);
  assign w_tick    = (r_h_cnt == '0) && (r_v_cnt == V_VIS_END);

  assign w_ball = (w_gx == r_snap_ball_x) && (w_gy == r_snap_ball_y);
  assign w_lpad = (w_gx == GX_LEFT)  && (absDiff(w_gy, r_snap_left)  <= PAD_EXT);
  assign w_rpad = (w_gx == GX_RIGHT) && (absDiff(w_gy, r_snap_right) <= PAD_EXT);

`ifdef PONG_RENDER_NET_EN
  localparam logic [7:0] GX_NET = 8'(GW >> 1);
  logic w_net;
  assign w_net  = (w_gx == GX_NET) && !w_gy[1];
  assign w_draw = w_ball || w_lpad || w_rpad || w_net;
`else
  assign w_draw = w_ball || w_lpad || w_rpad;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_pix_ce) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end
    end
  end

  // Positions are latched on the last strobe of the frame so a whole frame shows one game state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_snap_ball_x <= '0;
      r_snap_ball_y <= '0;
      r_snap_left   <= '0;
      r_snap_right  <= '0;
    end else if (i_pix_ce && w_h_last && w_v_last) begin
      r_snap_ball_x <= i_ball_x;
      r_snap_ball_y <= i_ball_y;
      r_snap_left   <= i_left_paddle_y;
      r_snap_right  <= i_right_paddle_y;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_pixel      <= 1'b0;
      r_active     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (i_pix_ce) begin
        r_hsync      <= ~w_hsync_n;
        r_vsync      <= ~w_vsync_n;
        r_pixel      <= w_vis && w_draw;
        r_active     <= w_vis;
        r_frame_tick <= w_tick;
      end
    end
  end

  assign o_hsync      = r_hsync;
  assign o_vsync      = r_vsync;
  assign o_pixel      = r_pixel;
  assign o_active     = r_active;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: doc/pong_raster_renderer.md
Name: pong_raster_renderer

Overview:
- Downstream display stage for the pong game-state block.
- Scans a VGA-style raster and consumes the ball and paddle positions on the game grid. Produces registered sync signals and a 1-bit pixel.
- Issues a once-per-frame tick that advances the game state. It replaces the external game-step strobe.
- Positions are snapshotted at frame start, so a frame never shows a partial update.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SCALE_SHIFT, 3, log2 of screen pixels per game cell (default grid is 80x60)
- PADDLE_EXTENT, 4, paddle half-height in cells

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_ce  in  1  pixel strobe; counters and outputs advance only when high
- ball_x  in  8  ball column, in cells
- ball_y  in  8  ball row, in cells
- left_paddle_y  in  8  left paddle centre row
- right_paddle_y  in  8  right paddle centre row
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- pixel  out  1  1 = lit
- active  out  1  1 while inside the visible area
- frame_tick  out  1  one-clk pulse at vblank start

Behaviour:
- Reset values (synchronous, highest priority, wins over pix_ce):
  - h_cnt=0, v_cnt=0, all snapshots=0
  - hsync=1, vsync=1, pixel=0, active=0, frame_tick=0
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL similarly (default 525).
- Counter widths: each counter is clog2 of its total.
- Counters, updated only on pix_ce:
  - h_cnt increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
- pix_ce low: all counters and registered outputs hold, except frame_tick, which is forced to 0.
- Snapshot:
  - On the pix_ce cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, capture all four position inputs.
  - Rendering uses only the snapshots.
  - Input changes at any other time are invisible until the next frame.
- Decode, from current counters, registered on pix_ce (1 pix_ce latency; all outputs mutually aligned):
  - vis = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE)
  - hsync low iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vsync low iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC
  - gx = h_cnt>>SCALE_SHIFT, gy = v_cnt>>SCALE_SHIFT, both zero-extended to 8 bits
  - GW = H_ACTIVE>>SCALE_SHIFT
  - ball = (gx==snap_ball_x) && (gy==snap_ball_y)
  - lpad = (gx==0) && |gy - snap_left| <= PADDLE_EXTENT
  - rpad = (gx==GW-1) && |gy - snap_right| <= PADDLE_EXTENT
  - The absolute difference is computed as a 9-bit signed subtraction. There is no 8-bit wrap, so a paddle at row 2 does not light row 250.
  - pixel = vis && (ball || lpad || rpad)
  - active = vis
- Off-grid positions (e.g. ball_x >= GW) are drawn nowhere, with no error.
- frame_tick = 1 for exactly the clk cycle of the pix_ce where h_cnt=0 and v_cnt=V_ACTIVE; else 0.
  - It is intended to clock or enable the game-state update during vblank.
  - The snapshot occurs later in the same frame, so each new position is shown starting the next frame.
- Reset mid-frame: the raster restarts at (0,0). The first frame after reset renders zeroed snapshots (a ball at cell 0,0 plus paddles centred at row 0).

Optional Feature:
- Macro: PONG_RENDER_NET_EN.
- Defined: also light the centre net, i.e. pixels where gx==(GW>>1) and gy[1]==0 (dashed, 2 cells on / 2 off), ORed into pixel, gated by vis.
- Undefined: no net logic is synthesised; pixel is exactly ball||lpad||rpad gated by vis.

Test Plan:
- Timing, reset then pix_ce=1 continuously:
  - hsync low for exactly 96 strobes starting 656 strobes after line start, period 800.
  - vsync low for 2 lines starting at line 490, period 525 lines.
  - Outputs lag the counters by one strobe.
- Ball draw: ball=(10,5), applied before the snapshot -> next frame, pixel=1 exactly for h 80..87, v 40..47 (plus paddle pixels); all other non-paddle pixels 0.
- Paddles, left_paddle_y=2, right_paddle_y=30 -> pixels lit at:
  - h 0..7 for gy 0..6 (no lit rows near gy 254)
  - h 632..639 for gy 26..34
- Snapshot isolation: change ball_x mid-frame at v=100 -> current frame unchanged; the change appears from the next frame.
- pix_ce pattern 1-of-4 -> timing identical when counted in strobes; frame_tick fires once per 420000 strobes and is never wider than 1 clk.
- Reset asserted at h=300, v=200 with pix_ce=1 -> the next cycle shows reset values; counting resumes from (0,0) after reset deasserts. With PONG_RENDER_NET_EN defined, the net lights h 320..327 on gy 0,1,4,5,...
